alarm_scheduler: RTL and testbench

Alarm arbiter and sequencer for the fish-tank controller. It takes three alarm requesters:
- debounced gas alarm
- over-temperature, derived here with hysteresis from DHT11 samples
- external alarm (e.g. low water)

It grants the shared buzzer and fan to the highest-priority active source and drives a per-source beep cadence. It also handles operator acknowledge/mute and a fan run-on period after all alarms clear.

---
 rtl/alarm_scheduler_if.sv | 26 ++
 rtl/alarm_scheduler.sv | 219 +++++++++++++++++++++
 tb/tb_alarm_scheduler.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alarm_scheduler_if.sv
// Alarm scheduler bus: alarm requests and operator input toward the
// scheduler, buzzer/fan/status outputs back from it.
interface alarm_scheduler_if;
  logic       gas_alarm;
  logic [7:0] temperature;
  logic       temp_valid;
  logic       ext_alarm;
  logic       ack;
  logic       buzzer_n;
  logic       fan_en;
  logic [1:0] active_src;
  logic       muted;
  logic [2:0] pending;

  // Requester side: drives alarm inputs, observes scheduler outputs
  modport master (
    output gas_alarm, temperature, temp_valid, ext_alarm, ack,
    input  buzzer_n, fan_en, active_src, muted, pending
  );

  // Scheduler side
  modport slave (
    input  gas_alarm, temperature, temp_valid, ext_alarm, ack,
    output buzzer_n, fan_en, active_src, muted, pending
  );
endinterface

// File: rtl/alarm_scheduler.sv
// Alarm arbiter/sequencer for the fish-tank controller. Grants the shared
// buzzer and fan to the highest-priority alarm (gas > temp > ext), drives a
// per-source beep cadence, handles operator mute and a fan run-on period.
module alarm_scheduler #(
  parameter int         CLK_PER_MS  = 50000,
  parameter logic [7:0] TEMP_HI     = 8'd40,
  parameter logic [7:0] TEMP_LO     = 8'd37,
  parameter int         BEEP_ON_MS  = 200,
  parameter int         GAS_OFF_MS  = 200,
  parameter int         TEMP_OFF_MS = 800,
  parameter int         EXT_OFF_MS  = 1800,
  parameter int         FAN_HOLD_MS = 5000
) (
  input logic               clk,
  input logic               rst_n,
  alarm_scheduler_if.slave  bus
);

  localparam int          PW          = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_PER_MS - 1);
  localparam logic [15:0] BEEP_ON_W   = 16'(BEEP_ON_MS);
  localparam logic [15:0] GAS_OFF_W   = 16'(GAS_OFF_MS);
  localparam logic [15:0] TEMP_OFF_W  = 16'(TEMP_OFF_MS);
  localparam logic [15:0] EXT_OFF_W   = 16'(EXT_OFF_MS);
  localparam logic [15:0] FAN_HOLD_W  = 16'(FAN_HOLD_MS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALARM = 2'd1,
    MUTED = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t        state_r;
  logic [1:0]    src_r;
  logic [PW-1:0] presc_r;
  logic [15:0]   ms_cnt_r;
  logic          beep_on_r;
  logic          temp_hot_r;
  logic [2:0]    pending_r;
  logic          buzzer_n_r;
  logic          fan_en_r;
  logic [1:0]    active_src_r;
  logic          muted_r;

  logic [1:0]    winner_s;
  logic          tick_s;
  logic [15:0]   ms_next_s;

  // OFF-phase length of the cadence belonging to a source
  function automatic logic [15:0] off_len(input logic [1:0] src);
    case (src)
      2'd1:    off_len = GAS_OFF_W;
      2'd2:    off_len = TEMP_OFF_W;
      2'd3:    off_len = EXT_OFF_W;
      default: off_len = GAS_OFF_W;
    endcase
  endfunction

  // Highest-priority pending request: bit0 gas, bit1 temp, bit2 ext
  always_comb begin
    winner_s = 2'd0;
    if (pending_r[0]) begin
      winner_s = 2'd1;
    end else if (pending_r[1]) begin
      winner_s = 2'd2;
    end else if (pending_r[2]) begin
      winner_s = 2'd3;
    end else begin
      winner_s = 2'd0;
    end
  end

  // Millisecond tick on prescaler wrap and next ms count
  always_comb begin
    tick_s    = (presc_r == PRESC_MAX);
    ms_next_s = ms_cnt_r + 16'd1;
  end

  // Over-temperature hysteresis and request registering
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      temp_hot_r <= 1'b0;
      pending_r  <= 3'b000;
    end else begin
      if (bus.temp_valid) begin
        if (bus.temperature >= TEMP_HI) begin
          temp_hot_r <= 1'b1;
        end else if (bus.temperature < TEMP_LO) begin
          temp_hot_r <= 1'b0;
        end
      end
      pending_r <= {bus.ext_alarm, temp_hot_r, bus.gas_alarm};
    end
  end

  // Scheduler FSM with timebase, cadence and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      src_r        <= 2'd0;
      presc_r      <= {PW{1'b0}};
      ms_cnt_r     <= 16'd0;
      beep_on_r    <= 1'b1;
      buzzer_n_r   <= 1'b1;
      fan_en_r     <= 1'b0;
      active_src_r <= 2'd0;
      muted_r      <= 1'b0;
    end else begin
      presc_r <= tick_s ? {PW{1'b0}} : presc_r + PW'(1);
      case (state_r)
        IDLE: begin
          presc_r      <= {PW{1'b0}};
          ms_cnt_r     <= 16'd0;
          buzzer_n_r   <= 1'b1;
          fan_en_r     <= 1'b0;
          active_src_r <= 2'd0;
          muted_r      <= 1'b0;
          if (pending_r != 3'b000) begin
            state_r      <= ALARM;
            src_r        <= winner_s;
            active_src_r <= winner_s;
            beep_on_r    <= 1'b1;
            buzzer_n_r   <= 1'b0;
            fan_en_r     <= 1'b1;
          end
        end
        ALARM: begin
          if (pending_r == 3'b000) begin
            state_r      <= HOLD;
            presc_r      <= {PW{1'b0}};
            ms_cnt_r     <= 16'd0;
            buzzer_n_r   <= 1'b1;
            active_src_r <= 2'd0;
          end else if (winner_s != src_r) begin
            // Preemption or fallback: restart cadence at ON, ack dropped
            src_r        <= winner_s;
            active_src_r <= winner_s;
            presc_r      <= {PW{1'b0}};
            ms_cnt_r     <= 16'd0;
            beep_on_r    <= 1'b1;
            buzzer_n_r   <= 1'b0;
          end else if (bus.ack) begin
            state_r    <= MUTED;
            presc_r    <= {PW{1'b0}};
            ms_cnt_r   <= 16'd0;
            buzzer_n_r <= 1'b1;
            muted_r    <= 1'b1;
          end else if (tick_s) begin
            if (beep_on_r && (ms_next_s == BEEP_ON_W)) begin
              beep_on_r  <= 1'b0;
              ms_cnt_r   <= 16'd0;
              buzzer_n_r <= 1'b1;
            end else if (!beep_on_r && (ms_next_s == off_len(src_r))) begin
              beep_on_r  <= 1'b1;
              ms_cnt_r   <= 16'd0;
              buzzer_n_r <= 1'b0;
            end else begin
              ms_cnt_r <= ms_next_s;
            end
          end
        end
        MUTED: begin
          presc_r  <= {PW{1'b0}};
          ms_cnt_r <= 16'd0;
          if (pending_r == 3'b000) begin
            state_r      <= HOLD;
            active_src_r <= 2'd0;
            muted_r      <= 1'b0;
          end else if (winner_s != src_r) begin
            state_r      <= ALARM;
            src_r        <= winner_s;
            active_src_r <= winner_s;
            beep_on_r    <= 1'b1;
            buzzer_n_r   <= 1'b0;
            muted_r      <= 1'b0;
          end
        end
        HOLD: begin
          if (pending_r != 3'b000) begin
            state_r      <= ALARM;
            src_r        <= winner_s;
            active_src_r <= winner_s;
            presc_r      <= {PW{1'b0}};
            ms_cnt_r     <= 16'd0;
            beep_on_r    <= 1'b1;
            buzzer_n_r   <= 1'b0;
          end else if (tick_s) begin
            if (ms_next_s == FAN_HOLD_W) begin
              state_r  <= IDLE;
              ms_cnt_r <= 16'd0;
              fan_en_r <= 1'b0;
            end else begin
              ms_cnt_r <= ms_next_s;
            end
          end
        end
        default: begin
          state_r      <= IDLE;
          src_r        <= 2'd0;
          presc_r      <= {PW{1'b0}};
          ms_cnt_r     <= 16'd0;
          beep_on_r    <= 1'b1;
          buzzer_n_r   <= 1'b1;
          fan_en_r     <= 1'b0;
          active_src_r <= 2'd0;
          muted_r      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.buzzer_n   = buzzer_n_r;
  assign bus.fan_en     = fan_en_r;
  assign bus.active_src = active_src_r;
  assign bus.muted      = muted_r;
  assign bus.pending    = pending_r;

endmodule

// File: tb/tb_alarm_scheduler.sv
// Scoreboard bench for alarm_scheduler: stimulus pushes cycle-stamped
// expected output tuples, a negedge monitor pops and compares them.
module tb_alarm_scheduler;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   base = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  alarm_scheduler_if bus();

  alarm_scheduler #(
    .CLK_PER_MS (10),
    .BEEP_ON_MS (2),
    .GAS_OFF_MS (2),
    .TEMP_OFF_MS(4),
    .EXT_OFF_MS (6),
    .FAN_HOLD_MS(5)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Expected tuple {buzzer_n, fan_en, active_src[1:0], muted, pending[2:0]}
  typedef struct {
    int         cyc;
    string      name;
    logic [7:0] val;
  } sb_entry_t;

  sb_entry_t sb[$];
  sb_entry_t mon_e;
  logic [7:0] act;

  initial forever #5 clk = ~clk;

  // Cycle counter: number of rising edges so far
  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  // Monitor: compares every expectation due at this falling edge
  initial forever begin
    @(negedge clk);
    act = {bus.buzzer_n, bus.fan_en, bus.active_src, bus.muted, bus.pending};
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      mon_e = sb.pop_front();
      n_checks = n_checks + 1;
      if (mon_e.cyc < cyc) begin
        n_fail = n_fail + 1;
        $display("FAIL %s: check for cycle %0d missed (now %0d)", mon_e.name, mon_e.cyc, cyc);
      end else if (act !== mon_e.val) begin
        n_fail = n_fail + 1;
        $display("FAIL %s: cycle %0d {bz,fan,src,mu,pend} actual %b required %b",
                 mon_e.name, cyc, act, mon_e.val);
      end
    end
  end

  task automatic mark();
    base = cyc;
  endtask

  task automatic go(input int dt);
    while (cyc < base + dt) @(negedge clk);
  endtask

  task automatic sb_push(input int dt, input string name, input logic bz, input logic fan,
                         input logic [1:0] src, input logic mu, input logic [2:0] pend);
    sb_entry_t e;
    e.cyc  = base + dt;
    e.name = name;
    e.val  = {bz, fan, src, mu, pend};
    sb.push_back(e);
  endtask

  task automatic do_reset();
    mark();
    rst_n            = 1'b0;
    bus.gas_alarm    = 1'b0;
    bus.temperature  = 8'd25;
    bus.temp_valid   = 1'b0;
    bus.ext_alarm    = 1'b0;
    bus.ack          = 1'b0;
    sb_push(1, "reset", 1'b1, 1'b0, 2'd0, 1'b0, 3'b000);
    go(2);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n           = 1'b0;
    bus.gas_alarm   = 1'b0;
    bus.temperature = 8'd25;
    bus.temp_valid  = 1'b0;
    bus.ext_alarm   = 1'b0;
    bus.ack         = 1'b0;
    do_reset();

    // 1: gas alarm, 20 low / 20 high cadence
    mark();
    bus.gas_alarm = 1'b1;
    sb_push(1,  "s1_pend",    1'b1, 1'b0, 2'd0, 1'b0, 3'b001);
    sb_push(2,  "s1_alarm",   1'b0, 1'b1, 2'd1, 1'b0, 3'b001);
    sb_push(21, "s1_on_end",  1'b0, 1'b1, 2'd1, 1'b0, 3'b001);
    sb_push(22, "s1_off",     1'b1, 1'b1, 2'd1, 1'b0, 3'b001);
    sb_push(41, "s1_off_end", 1'b1, 1'b1, 2'd1, 1'b0, 3'b001);
    sb_push(42, "s1_on2",     1'b0, 1'b1, 2'd1, 1'b0, 3'b001);
    go(43);
    do_reset();

    // 2: temperature hysteresis, 20/40 cadence, HOLD exactly 50 cycles
    mark();
    bus.temperature = 8'd40;
    bus.temp_valid  = 1'b1;
    sb_push(2,  "s2_pend",    1'b1, 1'b0, 2'd0, 1'b0, 3'b010);
    sb_push(3,  "s2_alarm",   1'b0, 1'b1, 2'd2, 1'b0, 3'b010);
    sb_push(22, "s2_on_end",  1'b0, 1'b1, 2'd2, 1'b0, 3'b010);
    sb_push(23, "s2_off",     1'b1, 1'b1, 2'd2, 1'b0, 3'b010);
    sb_push(62, "s2_off_end", 1'b1, 1'b1, 2'd2, 1'b0, 3'b010);
    sb_push(63, "s2_on2",     1'b0, 1'b1, 2'd2, 1'b0, 3'b010);
    go(1);
    bus.temp_valid = 1'b0;
    go(64);
    bus.temperature = 8'd38;
    bus.temp_valid  = 1'b1;
    go(65);
    bus.temp_valid = 1'b0;
    sb_push(67, "s2_hold38",  1'b0, 1'b1, 2'd2, 1'b0, 3'b010);
    go(70);
    bus.temperature = 8'd36;
    bus.temp_valid  = 1'b1;
    go(71);
    bus.temp_valid = 1'b0;
    sb_push(73,  "s2_hold_in",  1'b1, 1'b1, 2'd0, 1'b0, 3'b000);
    sb_push(122, "s2_hold_end", 1'b1, 1'b1, 2'd0, 1'b0, 3'b000);
    sb_push(123, "s2_idle",     1'b1, 1'b0, 2'd0, 1'b0, 3'b000);
    go(124);

    // 3: ext alarm preempted by gas, then fallback to ext
    mark();
    bus.ext_alarm = 1'b1;
    sb_push(1, "s3_pend",  1'b1, 1'b0, 2'd0, 1'b0, 3'b100);
    sb_push(2, "s3_alarm", 1'b0, 1'b1, 2'd3, 1'b0, 3'b100);
    go(10);
    bus.gas_alarm = 1'b1;
    sb_push(11, "s3_pre_sw",   1'b0, 1'b1, 2'd3, 1'b0, 3'b101);
    sb_push(12, "s3_preempt",  1'b0, 1'b1, 2'd1, 1'b0, 3'b101);
    sb_push(31, "s3_gas_on",   1'b0, 1'b1, 2'd1, 1'b0, 3'b101);
    sb_push(32, "s3_gas_off",  1'b1, 1'b1, 2'd1, 1'b0, 3'b101);
    go(35);
    bus.gas_alarm = 1'b0;
    sb_push(36, "s3_pre_back", 1'b1, 1'b1, 2'd1, 1'b0, 3'b100);
    sb_push(37, "s3_fallback", 1'b0, 1'b1, 2'd3, 1'b0, 3'b100);
    sb_push(56, "s3_ext_on",   1'b0, 1'b1, 2'd3, 1'b0, 3'b100);
    sb_push(57, "s3_ext_off",  1'b1, 1'b1, 2'd3, 1'b0, 3'b100);
    go(58);
    do_reset();

    // 4/5: mute, unmute by higher priority, ack dropped on source change,
    // ack ignored in HOLD and IDLE
    mark();
    bus.temperature = 8'd40;
    bus.temp_valid  = 1'b1;
    sb_push(3, "s4_alarm", 1'b0, 1'b1, 2'd2, 1'b0, 3'b010);
    go(1);
    bus.temp_valid = 1'b0;
    go(5);
    bus.ack = 1'b1;
    sb_push(6,  "s4_muted",  1'b1, 1'b1, 2'd2, 1'b1, 3'b010);
    sb_push(30, "s4_mute_k", 1'b1, 1'b1, 2'd2, 1'b1, 3'b010);
    go(6);
    bus.ack = 1'b0;
    go(31);
    bus.gas_alarm = 1'b1;
    sb_push(32, "s4_pre_gas", 1'b1, 1'b1, 2'd2, 1'b1, 3'b011);
    sb_push(33, "s4_unmute",  1'b0, 1'b1, 2'd1, 1'b0, 3'b011);
    go(40);
    bus.gas_alarm = 1'b0;
    go(41);
    bus.ack = 1'b1;
    sb_push(42, "s5_ack_sw", 1'b0, 1'b1, 2'd2, 1'b0, 3'b010);
    sb_push(43, "s5_no_mute", 1'b0, 1'b1, 2'd2, 1'b0, 3'b010);
    go(42);
    bus.ack = 1'b0;
    go(45);
    bus.temperature = 8'd30;
    bus.temp_valid  = 1'b1;
    sb_push(48, "s5_hold", 1'b1, 1'b1, 2'd0, 1'b0, 3'b000);
    go(46);
    bus.temp_valid = 1'b0;
    go(50);
    bus.ack = 1'b1;
    sb_push(52, "s5_ack_hold", 1'b1, 1'b1, 2'd0, 1'b0, 3'b000);
    sb_push(97, "s5_hold_end", 1'b1, 1'b1, 2'd0, 1'b0, 3'b000);
    sb_push(98, "s5_idle",     1'b1, 1'b0, 2'd0, 1'b0, 3'b000);
    go(51);
    bus.ack = 1'b0;
    go(100);
    bus.ack = 1'b1;
    sb_push(102, "s5_ack_idle", 1'b1, 1'b0, 2'd0, 1'b0, 3'b000);
    go(101);
    bus.ack = 1'b0;
    go(103);

    // 6: HOLD interrupted at cycle 30, then reset mid-ON phase
    mark();
    bus.ext_alarm = 1'b1;
    sb_push(2, "s6_alarm", 1'b0, 1'b1, 2'd3, 1'b0, 3'b100);
    go(5);
    bus.ext_alarm = 1'b0;
    sb_push(7, "s6_hold", 1'b1, 1'b1, 2'd0, 1'b0, 3'b000);
    go(35);
    bus.ext_alarm = 1'b1;
    sb_push(36, "s6_hold30",  1'b1, 1'b1, 2'd0, 1'b0, 3'b100);
    sb_push(37, "s6_realarm", 1'b0, 1'b1, 2'd3, 1'b0, 3'b100);
    go(45);
    rst_n = 1'b0;
    sb_push(46, "s6_reset",  1'b1, 1'b0, 2'd0, 1'b0, 3'b000);
    sb_push(47, "s6_reset2", 1'b1, 1'b0, 2'd0, 1'b0, 3'b000);
    go(48);
    rst_n = 1'b1;
    sb_push(49, "s6_post_pend", 1'b1, 1'b0, 2'd0, 1'b0, 3'b100);
    sb_push(50, "s6_post_alarm", 1'b0, 1'b1, 2'd3, 1'b0, 3'b100);
    sb_push(69, "s6_post_on",   1'b0, 1'b1, 2'd3, 1'b0, 3'b100);
    sb_push(70, "s6_post_off",  1'b1, 1'b1, 2'd3, 1'b0, 3'b100);
    go(71);

    // Let the monitor drain the scoreboard, bounded
    for (int i = 0; i < 100 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      n_checks = n_checks + 1;
      n_fail = n_fail + 1;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
